// File: rtl/u712_pkg.sv
// Shared state encoding and Agnus DRAM address maps for the chip RAM cycle generator,
// the chip RAM controller and its benches.
package u712_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    RAS,
    COL,
    CAS,
    REF,
    PRE
  } state_t;

  localparam int CNT_W = 4;

  // a[20:1] is the word address; row carries A19 on top so bank select stays visible.
  function automatic logic [9:0] AGNUS_ROW_MAP(input logic [20:1] a);
    return {a[19], a[17:9]};
  endfunction

  // In the 1MB map A20 is dropped and column MA9 reads as zero.
  function automatic logic [9:0] AGNUS_COL_MAP(input logic [20:1] a, input logic map_2mb);
    return {map_2mb & a[20], a[18], a[8:1]};
  endfunction

endpackage

// File: rtl/u712_dram_cycle_gen_if.sv
// Request side plus multiplexed DRAM strobes of the cycle generator.
// master = requester/bench, slave = cycle generator.
interface u712_dram_cycle_gen_if;
  logic        REQ;
  logic        REQ_RnW;
  logic [20:1] REQ_A;
  logic        REQ_UDS;
  logic        REQ_LDS;
  logic        REFRESH_REQ;
  logic        ACK;
  logic        BUSY;
  logic        nRAS0;
  logic        nRAS1;
  logic        nCASU;
  logic        nCASL;
  logic        nAWE;
  logic [9:0]  DRA;

  modport master (
    output REQ, REQ_RnW, REQ_A, REQ_UDS, REQ_LDS, REFRESH_REQ,
    input  ACK, BUSY, nRAS0, nRAS1, nCASU, nCASL, nAWE, DRA
  );

  modport slave (
    input  REQ, REQ_RnW, REQ_A, REQ_UDS, REQ_LDS, REFRESH_REQ,
    output ACK, BUSY, nRAS0, nRAS1, nCASU, nCASL, nAWE, DRA
  );
endinterface

// File: rtl/u712_dram_addr_mux.sv
// Purpose: select row or column DRA image of a word address for the chosen Agnus map.
// Latency: purely combinational.
// Backpressure: none.
module u712_dram_addr_mux
  import u712_pkg::*;
#(
  parameter bit AGNUS_2MB = 1'b0
) (
  input  logic [20:1] addr,
  input  logic        sel_col,
  output logic [9:0]  dra
);

  assign dra = sel_col ? AGNUS_COL_MAP(addr, AGNUS_2MB) : AGNUS_ROW_MAP(addr);

endmodule

// File: rtl/u712_dram_cycle_gen.sv
// Purpose: turn word requests into timed Agnus row/column DRAM cycles plus RAS-only refresh.
// Latency: request to ACK is 3 + RAS_TO_CAS + CAS_WIDTH clocks, then PRECHARGE + 1 before the next.
// Backpressure: REQ is held until ACK; nothing is sampled outside IDLE.
module u712_dram_cycle_gen
  import u712_pkg::*;
#(
  parameter int RAS_TO_CAS = 4,
  parameter int CAS_WIDTH  = 8,
  parameter int PRECHARGE  = 6,
  parameter int AGNUS_2MB  = 0
) (
  input  logic                  CLK80,
  input  logic                  nRESET,
  u712_dram_cycle_gen_if.slave  bus
);

  if (RAS_TO_CAS < 1 || RAS_TO_CAS > 15 || CAS_WIDTH < 1 || CAS_WIDTH > 15 ||
      PRECHARGE < 1 || PRECHARGE > 15 || AGNUS_2MB < 0 || AGNUS_2MB > 1) begin : g_bad_param
    $error("u712_dram_cycle_gen: timing parameters must be 1..15 and AGNUS_2MB 0 or 1");
  end

  localparam logic [CNT_W-1:0] R2C_LD = RAS_TO_CAS[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CAS_LD = CAS_WIDTH[CNT_W-1:0];
  localparam logic [CNT_W-1:0] PRE_LD = PRECHARGE[CNT_W-1:0];

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_dec;
  logic [20:1]      a_q, a_nxt;
  logic             rnw_q, rnw_nxt, uds_q, uds_nxt, lds_q, lds_nxt;
  logic             nras0_q, nras0_nxt, nras1_q, nras1_nxt;
  logic             ncasu_q, ncasu_nxt, ncasl_q, ncasl_nxt;
  logic             nawe_q, nawe_nxt, ack_q, ack_nxt, busy_q, busy_nxt;
  logic [9:0]       dra_q, dra_nxt, mux_dra;
  logic [20:1]      mux_addr;
  logic             mux_col;

  // Row comes straight from the request while leaving IDLE; column only ever from the capture.
  assign mux_addr = (state == IDLE) ? bus.REQ_A : a_q;
  assign mux_col  = (state != IDLE);

  u712_dram_addr_mux #(.AGNUS_2MB(AGNUS_2MB != 0)) u_addr_mux (
    .addr    (mux_addr),
    .sel_col (mux_col),
    .dra     (mux_dra)
  );

  always_ff @(posedge CLK80 or negedge nRESET) begin
    if (!nRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      rnw_q   <= 1'b1;
      uds_q   <= 1'b0;
      lds_q   <= 1'b0;
      nras0_q <= 1'b1;
      nras1_q <= 1'b1;
      ncasu_q <= 1'b1;
      ncasl_q <= 1'b1;
      nawe_q  <= 1'b1;
      dra_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      a_q     <= a_nxt;
      rnw_q   <= rnw_nxt;
      uds_q   <= uds_nxt;
      lds_q   <= lds_nxt;
      nras0_q <= nras0_nxt;
      nras1_q <= nras1_nxt;
      ncasu_q <= ncasu_nxt;
      ncasl_q <= ncasl_nxt;
      nawe_q  <= nawe_nxt;
      dra_q   <= dra_nxt;
      ack_q   <= ack_nxt;
      busy_q  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cnt_dec   = cnt - 4'd1;
    a_nxt     = a_q;
    rnw_nxt   = rnw_q;
    uds_nxt   = uds_q;
    lds_nxt   = lds_q;
    nras0_nxt = nras0_q;
    nras1_nxt = nras1_q;
    ncasu_nxt = ncasu_q;
    ncasl_nxt = ncasl_q;
    nawe_nxt  = nawe_q;
    dra_nxt   = dra_q;
    ack_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.REFRESH_REQ) begin
          nras0_nxt = 1'b0;
          nras1_nxt = 1'b0;
          cnt_nxt   = CAS_LD;
          state_nxt = REF;
        end else if (bus.REQ) begin
          a_nxt     = bus.REQ_A;
          rnw_nxt   = bus.REQ_RnW;
          uds_nxt   = bus.REQ_UDS;
          lds_nxt   = bus.REQ_LDS;
          dra_nxt   = mux_dra;
          state_nxt = ROW;
        end
      end
      ROW: begin
        nras0_nxt = a_q[19];
        nras1_nxt = ~a_q[19];
        cnt_nxt   = R2C_LD;
        state_nxt = RAS;
      end
      RAS: begin
        cnt_nxt = cnt_dec;
        if (cnt_dec == '0) begin
          dra_nxt   = mux_dra;
          nawe_nxt  = rnw_q;    // early write: WE settles a clock before CAS
          state_nxt = COL;
        end
      end
      COL: begin
        // No byte enable at all is treated as a full word access.
        ncasu_nxt = ~uds_q & lds_q;
        ncasl_nxt = ~lds_q & uds_q;
        cnt_nxt   = CAS_LD;
        state_nxt = CAS;
      end
      CAS: begin
        cnt_nxt = cnt_dec;
        if (cnt_dec == '0) begin
          nras0_nxt = 1'b1;
          nras1_nxt = 1'b1;
          ncasu_nxt = 1'b1;
          ncasl_nxt = 1'b1;
          nawe_nxt  = 1'b1;
          ack_nxt   = 1'b1;
          cnt_nxt   = PRE_LD;
          state_nxt = PRE;
        end
      end
      REF: begin
        cnt_nxt = cnt_dec;
        if (cnt_dec == '0) begin
          nras0_nxt = 1'b1;
          nras1_nxt = 1'b1;
          cnt_nxt   = PRE_LD;
          state_nxt = PRE;
        end
      end
      PRE: begin
        cnt_nxt = cnt_dec;
        if (cnt_dec == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.ACK   = ack_q;
  assign bus.BUSY  = busy_q;
  assign bus.nRAS0 = nras0_q;
  assign bus.nRAS1 = nras1_q;
  assign bus.nCASU = ncasu_q;
  assign bus.nCASL = ncasl_q;
  assign bus.nAWE  = nawe_q;
  assign bus.DRA   = dra_q;

endmodule

// File: tb/tb_u712_dram_cycle_gen.sv
// Bench for u712_dram_cycle_gen: 1MB and 2MB instances driven in lockstep, cycle-exact
// expectations per clock, ACK scoreboard and a WE-under-CAS watchdog.
module tb_u712_dram_cycle_gen;

  localparam int R    = 4;
  localparam int C    = 8;
  localparam int P    = 6;
  localparam int DLEN = R + C + 3;

  typedef struct packed {
    logic       nras0, nras1, ncasu, ncasl, nawe, ack, busy;
    logic [9:0] dra;
  } out_t;

  typedef struct {
    logic        rnw;
    logic [20:1] a;
    logic        uds, lds;
    logic [9:0]  row, col0, col1;
  } vec_t;

  typedef struct packed {
    logic [9:0] col0, col1;
  } sb_t;

  localparam out_t IDLE_OUT = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000};

  logic        CLK80 = 1'b0;
  logic        nRESET = 1'b0;
  logic        req = 1'b0, rnw = 1'b1, uds = 1'b0, lds = 1'b0, ref_req = 1'b0;
  logic [20:1] addr = '0;

  int   total = 0, bad = 0, cyc = 0, ack_cyc = 0;
  logic [9:0] last0 = '0, last1 = '0;
  logic nawe_prev = 1'b1;
  sb_t  sbq[$];
  vec_t vt[6];

  u712_dram_cycle_gen_if b0();
  u712_dram_cycle_gen_if b1();

  assign b0.REQ = req;  assign b0.REQ_RnW = rnw;  assign b0.REQ_A = addr;
  assign b0.REQ_UDS = uds;  assign b0.REQ_LDS = lds;  assign b0.REFRESH_REQ = ref_req;
  assign b1.REQ = req;  assign b1.REQ_RnW = rnw;  assign b1.REQ_A = addr;
  assign b1.REQ_UDS = uds;  assign b1.REQ_LDS = lds;  assign b1.REFRESH_REQ = ref_req;

  u712_dram_cycle_gen #(.RAS_TO_CAS(R), .CAS_WIDTH(C), .PRECHARGE(P), .AGNUS_2MB(0)) dut0 (
    .CLK80(CLK80), .nRESET(nRESET), .bus(b0.slave));
  u712_dram_cycle_gen #(.RAS_TO_CAS(R), .CAS_WIDTH(C), .PRECHARGE(P), .AGNUS_2MB(1)) dut1 (
    .CLK80(CLK80), .nRESET(nRESET), .bus(b1.slave));

  always #5 CLK80 = ~CLK80;
  always @(posedge CLK80) cyc = cyc + 1;

  function automatic out_t got(input bit d1);
    if (d1) return {b1.nRAS0, b1.nRAS1, b1.nCASU, b1.nCASL, b1.nAWE, b1.ACK, b1.BUSY, b1.DRA};
    return {b0.nRAS0, b0.nRAS1, b0.nCASU, b0.nCASL, b0.nAWE, b0.ACK, b0.BUSY, b0.DRA};
  endfunction

  // Expected outputs k clocks after IDLE accepted a data request.
  function automatic out_t exp_data(input int k, input vec_t v, input logic [9:0] col);
    out_t o;
    o = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, v.row};
    if (k >= 2 && k <= R + C + 2) begin
      if (v.a[19]) o.nras1 = 1'b0;
      else         o.nras0 = 1'b0;
    end
    if (k >= R + 2) o.dra = col;
    if (!v.rnw && k >= R + 2 && k <= R + C + 2) o.nawe = 1'b0;
    if (k >= R + 3 && k <= R + C + 2) begin
      if (v.uds == v.lds) begin o.ncasu = 1'b0; o.ncasl = 1'b0; end
      else if (v.uds)     o.ncasu = 1'b0;
      else                o.ncasl = 1'b0;
    end
    if (k == DLEN) o.ack = 1'b1;
    if (k >= DLEN + P) o.busy = 1'b0;
    return o;
  endfunction

  function automatic out_t exp_ref(input int k, input logic [9:0] held);
    out_t o;
    o = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, held};
    if (k <= C) begin o.nras0 = 1'b0; o.nras1 = 1'b0; end
    if (k >= C + P + 1) o.busy = 1'b0;
    return o;
  endfunction

  task automatic check(input string what, input int k, input out_t act, input out_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s k=%0d ras0,ras1,casu,casl,awe,ack,busy=%b%b%b%b%b%b%b dra=%h, required %b%b%b%b%b%b%b dra=%h",
               what, k, act.nras0, act.nras1, act.ncasu, act.ncasl, act.nawe, act.ack, act.busy, act.dra,
               exp.nras0, exp.nras1, exp.ncasu, exp.ncasl, exp.nawe, exp.ack, exp.busy, exp.dra);
    end
  endtask

  // Entered just after a falling edge; drives the request and follows it clock by clock.
  task automatic do_xfer(input vec_t v, input bit hold, input int abort_k, input bit chk_gap);
    req = 1'b1; rnw = v.rnw; addr = v.a; uds = v.uds; lds = v.lds;
    sbq.push_back({v.col0, v.col1});
    for (int k = 1; k <= DLEN + P; k++) begin
      @(negedge CLK80);
      check("data_1mb", k, got(0), exp_data(k, v, v.col0));
      check("data_2mb", k, got(1), exp_data(k, v, v.col1));
      if (k == 1) begin
        if (chk_gap) begin
          total++;
          if (cyc - ack_cyc != P + 1) begin
            bad++;
            $display("FAIL ack_to_row gap=%0d required %0d", cyc - ack_cyc, P + 1);
          end
        end
        // Scramble inputs: the cycle must run from the captured copy.
        addr = ~v.a; rnw = ~v.rnw; uds = ~v.uds; lds = ~v.lds;
        if (!hold) req = 1'b0;
      end
      if (k == abort_k) begin
        #1 nRESET = 1'b0;
        #1;
        check("rst_mid_1mb", k, got(0), IDLE_OUT);
        check("rst_mid_2mb", k, got(1), IDLE_OUT);
        sbq.delete();
        req = 1'b0;
        @(negedge CLK80);
        check("rst_hold_1mb", k + 1, got(0), IDLE_OUT);
        nRESET = 1'b1;
        last0 = '0; last1 = '0;
        return;
      end
    end
    last0 = v.col0; last1 = v.col1;
  endtask

  // Scoreboard: every ACK must match a pushed request and carry its column on DRA.
  always @(negedge CLK80) begin
    if (nRESET && b0.ACK) begin
      sb_t e;
      ack_cyc = cyc;
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL ack_sb unexpected ACK at cycle %0d, no request outstanding", cyc);
      end else begin
        e = sbq.pop_front();
        if (b0.DRA !== e.col0 || b1.DRA !== e.col1) begin
          bad++;
          $display("FAIL ack_sb dra=%h/%h required %h/%h", b0.DRA, b1.DRA, e.col0, e.col1);
        end
      end
    end
  end

  always @(negedge CLK80) begin
    if (nRESET && (!b0.nCASU || !b0.nCASL)) begin
      total++;
      if (b0.nAWE !== nawe_prev) begin
        bad++;
        $display("FAIL awe_under_cas nAWE=%b was %b while CAS low", b0.nAWE, nawe_prev);
      end
    end
    nawe_prev = b0.nAWE;
  end

  initial begin
    vt[0] = '{rnw:1'b1, a:20'h12345, uds:1'b1, lds:1'b1, row:10'h123, col0:10'h045, col1:10'h045};
    vt[1] = '{rnw:1'b0, a:20'h40ABC, uds:1'b0, lds:1'b1, row:10'h20A, col0:10'h0BC, col1:10'h0BC};
    vt[2] = '{rnw:1'b1, a:20'h85A3C, uds:1'b1, lds:1'b0, row:10'h05A, col0:10'h03C, col1:10'h23C};
    vt[3] = '{rnw:1'b0, a:20'hFFFFF, uds:1'b0, lds:1'b0, row:10'h3FF, col0:10'h1FF, col1:10'h3FF};
    vt[4] = '{rnw:1'b0, a:20'h20001, uds:1'b1, lds:1'b0, row:10'h000, col0:10'h101, col1:10'h101};
    vt[5] = '{rnw:1'b1, a:20'h6AA55, uds:1'b1, lds:1'b1, row:10'h2AA, col0:10'h155, col1:10'h155};

    repeat (2) @(negedge CLK80);
    check("reset_1mb", 0, got(0), IDLE_OUT);
    check("reset_2mb", 0, got(1), IDLE_OUT);
    nRESET = 1'b1;
    @(negedge CLK80);
    check("post_reset_idle", 0, got(0), IDLE_OUT);

    for (int i = 0; i < 6; i++) do_xfer(vt[i], 1'b0, 0, 1'b0);

    // Refresh and data request rise together: refresh first, data after precharge.
    req = 1'b1; ref_req = 1'b1; rnw = vt[1].rnw; addr = vt[1].a; uds = vt[1].uds; lds = vt[1].lds;
    for (int k = 1; k <= C + P + 1; k++) begin
      @(negedge CLK80);
      if (k == 1) ref_req = 1'b0;
      check("refresh_1mb", k, got(0), exp_ref(k, last0));
      check("refresh_2mb", k, got(1), exp_ref(k, last1));
    end
    do_xfer(vt[1], 1'b0, 0, 1'b0);

    // Reset in the middle of CAS, then a full normal cycle.
    do_xfer(vt[0], 1'b0, R + 5, 1'b0);
    do_xfer(vt[5], 1'b0, 0, 1'b0);

    // Back-to-back writes with REQ held.
    do_xfer(vt[3], 1'b1, 0, 1'b0);
    do_xfer(vt[4], 1'b1, 0, 1'b1);
    do_xfer(vt[1], 1'b0, 0, 1'b1);

    repeat (3) @(negedge CLK80);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL ack_missing outstanding=%0d required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
